// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch unit and memory.
// Request side is level-held until the memory reports valid.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-issue fetch: owns PC, fetches one word, holds it for decode; 1 cycle after imem_valid.
// Backpressure: instr_ready=0 holds everything; misaligned taken redirect traps until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    input  logic               instr_ready,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    input  logic [31:0]        target_pc,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [6:0]         opcode,
    output logic [4:0]         rd,
    output logic [2:0]         funct3,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [6:0]         funct7,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fault,
    output logic [31:0]        instret
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        fault_q, fault_d;
    logic        taken;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        taken     = jump | (branch & zero);
        next_pc   = taken ? target_pc : pc_plus4;
        unique case (state_q)
            S_FETCH: begin
                if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    // instr_q reverts to NOP so it already reads as a bubble once invalid
                    instr_d = NOP_INSTR;
                    if (taken && (next_pc[1:0] != 2'b00)) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == S_FETCH) && rst_n;
    assign imem.imem_addr = pc_q;

    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign rd          = instr_q[11:7];
    assign funct3      = instr_q[14:12];
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign funct7      = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fault       = fault_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan sequences with literal checks,
// then randomized traffic compared every cycle against a queue-free behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        instr_ready, branch, jump, zero;
    logic [31:0] target_pc;
    logic        instr_valid, fault;
    logic [31:0] instr, pc, pc_plus4, instret;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .instr_ready (instr_ready),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .target_pc   (target_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference view: the instruction in hand (if any), the PC, retire count, trap flag.
    bit          m_have_instr;
    bit          m_trapped;
    logic [31:0] m_instr, m_pc, m_instret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_instr = 0;
        m_trapped    = 0;
        m_instr      = NOP;
        m_pc         = 32'h0;
        m_instret    = 32'h0;
    endtask

    // What one rising edge does, given the inputs currently applied.
    task automatic model_edge();
        logic [31:0] dest;
        bit          redirect;
        if (!rst_n || m_trapped) return;
        if (!m_have_instr) begin
            if (imem_bus.imem_valid) begin
                m_instr      = imem_bus.imem_rdata;
                m_have_instr = 1;
            end
        end else if (instr_ready) begin
            redirect     = jump || (branch && zero);
            dest         = redirect ? target_pc : m_pc + 32'd4;
            m_have_instr = 0;
            if (redirect && (dest % 4 != 0)) m_trapped = 1;
            else begin
                m_pc      = dest;
                m_instret = m_instret + 32'd1;
            end
        end
    endtask

    task automatic cmp_all();
        logic [31:0] ei;
        bit          ereq;
        ei   = m_have_instr ? m_instr : NOP;
        ereq = rst_n && !m_have_instr && !m_trapped;
        chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, ereq});
        if (ereq || !rst_n) chk("imem_addr", imem_bus.imem_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have_instr});
        chk("instr", instr, ei);
        chk("opcode", {25'b0, opcode}, {25'b0, ei[6:0]});
        chk("rd", {27'b0, rd}, {27'b0, ei[11:7]});
        chk("funct3", {29'b0, funct3}, {29'b0, ei[14:12]});
        chk("rs1", {27'b0, rs1}, {27'b0, ei[19:15]});
        chk("rs2", {27'b0, rs2}, {27'b0, ei[24:20]});
        chk("funct7", {25'b0, funct7}, {25'b0, ei[31:25]});
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fault", {31'b0, fault}, {31'b0, m_trapped});
        chk("instret", instret, m_instret);
    endtask

    // Inputs are set just after a falling edge; this advances one full clock.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1 cmp_all();
        @(posedge clk);
        @(negedge clk);
        cmp_all();
        rst_n = 1'b1;
        #1 cmp_all();
    endtask

    task automatic fetch(input logic [31:0] word, input int delay);
        logic [31:0] addr0;
        addr0 = imem_bus.imem_addr;
        imem_bus.imem_valid = 1'b0;
        for (int k = 0; k < delay; k++) begin
            cycle();
            chk("stall_req", {31'b0, imem_bus.imem_req}, 32'd1);
            chk("stall_addr", imem_bus.imem_addr, addr0);
        end
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = word;
        cycle();
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic consume(input logic br, input logic jp, input logic zr, input logic [31:0] tgt);
        instr_ready = 1'b1;
        branch = br; jump = jp; zero = zr; target_pc = tgt;
        cycle();
        instr_ready = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; target_pc = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; target_pc = 32'h0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Zero-wait memory, consumer always ready
        chk("t1_addr0", imem_bus.imem_addr, 32'h0);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 32'h0050_0093;
        instr_ready = 1'b1;
        cycle();
        imem_bus.imem_valid = 1'b0;
        chk("t1_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_opcode", {25'b0, opcode}, 32'h13);
        chk("t1_rd", {27'b0, rd}, 32'd1);
        chk("t1_funct3", {29'b0, funct3}, 32'd0);
        cycle();
        chk("t1_addr4", imem_bus.imem_addr, 32'h4);
        chk("t1_instret", instret, 32'd1);
        instr_ready = 1'b0;

        // Three-cycle memory wait, then a five-cycle consumer stall
        fetch(32'h00A0_0113, 3);
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t2_instr", instr, 32'h00A0_0113);
            chk("t2_pc", pc, 32'h4);
            chk("t2_instret", instret, 32'd1);
        end
        consume(0, 0, 0, 32'h0);

        // Branch taken / not taken from pc 8
        fetch(32'h0020_8463, 0);
        chk("t3_pc8", pc, 32'h8);
        consume(1, 0, 1, 32'h40);
        chk("t3_taken_addr", imem_bus.imem_addr, 32'h40);
        fetch(32'h0000_006F, 0);
        consume(0, 1, 0, 32'h8);
        fetch(32'h0020_8463, 0);
        consume(1, 0, 0, 32'h40);
        chk("t3_nottaken_addr", imem_bus.imem_addr, 32'hC);

        // Misaligned jump traps; memory responses are ignored while trapped
        fetch(32'h1000_006F, 0);
        consume(0, 1, 0, 32'h102);
        chk("t4_fault", {31'b0, fault}, 32'd1);
        chk("t4_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_pc", pc, 32'hC);
        chk("t4_instret", instret, 32'd5);
        imem_bus.imem_valid = 1'b1;
        cycle();
        cycle();
        imem_bus.imem_valid = 1'b0;
        chk("t4_still_fault", {31'b0, fault}, 32'd1);
        do_reset();
        chk("t4_rst_pc", pc, 32'h0);
        chk("t4_rst_instret", instret, 32'd0);
        chk("t4_rst_fault", {31'b0, fault}, 32'd0);
        chk("t4_rst_instr", instr, NOP);

        // PC wrap at top of address space
        fetch(32'h0000_006F, 0);
        consume(0, 1, 0, 32'hFFFF_FFFC);
        chk("t5_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0);
        chk("t5_pc_plus4", pc_plus4, 32'h0);
        consume(0, 0, 0, 32'h0);
        chk("t5_addr_wrap", imem_bus.imem_addr, 32'h0);
        chk("t5_fault", {31'b0, fault}, 32'd0);

        // Retire counter wrap
        fetch(32'h0000_0013, 0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        consume(0, 0, 0, 32'h0);
        chk("t6_instret_wrap", instret, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ((m_trapped && ($urandom_range(3) == 0)) || ($urandom_range(399) == 0)) begin
                do_reset();
            end else begin
                imem_bus.imem_valid = ($urandom_range(2) == 0);
                imem_bus.imem_rdata = $urandom;
                instr_ready = $urandom_range(1);
                jump   = ($urandom_range(7) == 0);
                branch = $urandom_range(1);
                zero   = $urandom_range(1);
                target_pc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(15) == 0) target_pc[1:0] = 2'($urandom_range(3));
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Single-issue instruction fetch unit that produces the instruction stream consumed by `control_unit`. It owns the PC, requests words from instruction memory through a valid handshake, and holds the fetched instruction in a register. The slices feeding `control_unit` (`opcode`, `funct3`, `funct7`) and the register-file index fields come from that register. On consumption it takes `branch`, `jump` and `zero` back from `control_unit`/ALU plus the computed target to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC after reset; must be word-aligned
- `NOP_INSTR`, 32'h0000_0013, value presented on `instr` when no valid instruction (addi x0,x0,0)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  byte address of requested word
- `imem_rdata`  in  32  returned instruction word
- `imem_valid`  in  1  `imem_rdata` valid this cycle
- `instr_ready`  in  1  downstream consumes the held instruction this cycle
- `branch`, `jump`, `zero`  in  1 each  from `control_unit` / ALU, for the held instruction
- `target_pc`  in  32  branch/jump target, for the held instruction
- `instr_valid`  out  1  `instr` and fields are valid
- `instr`  out  32  held instruction
- `opcode`  out  7  `instr[6:0]`
- `rd`  out  5  `instr[11:7]`
- `funct3`  out  3  `instr[14:12]`
- `rs1`  out  5  `instr[19:15]`
- `rs2`  out  5  `instr[24:20]`
- `funct7`  out  7  `instr[31:25]`
- `pc`  out  32  address of held instruction
- `pc_plus4`  out  32  `pc + 4`, mod 2^32
- `fault`  out  1  misaligned redirect trap, sticky
- `instret`  out  32  retired-instruction count, wraps

## Operation
- States: FETCH, HOLD, FAULT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both stay stable until `imem_valid`.
  - `imem_valid` is ignored unless `imem_req`=1.
  - On `imem_valid`: capture `imem_rdata` into `instr` and go to HOLD.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - `instr_ready`=0 is a stall: all outputs hold.
  - `instr_ready`=1 consumes the instruction:
    - taken = `jump` | (`branch` & `zero`).
    - Next PC = taken ? `target_pc` : `pc_plus4`.
    - `instret` increments; 32'hFFFF_FFFF wraps to 0.
    - Go to FETCH.
  - If taken and `target_pc[1:0]`≠0: `pc` is not updated, `instret` is not incremented, `fault`←1, go to FAULT.
- FAULT:
  - `imem_req`=0, `instr_valid`=0.
  - Remains until reset.
- Whenever `instr_valid`=0, `instr` shows `NOP_INSTR` and the fields are sliced from it (`opcode`=7'b0010011, all other fields 0).
- `branch`, `jump`, `zero` and `target_pc` are sampled only at a consuming edge.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0 with no fault.

## Timing
- Reset values, applied asynchronously the moment `rst_n`=0:
  - state FETCH, `pc`=`RESET_PC`, `instr`=`NOP_INSTR`.
  - `instr_valid`=0, `fault`=0, `instret`=0.
  - `imem_req`=0 while `rst_n`=0; it goes to 1 combinationally once `rst_n`=1.
  - `imem_addr`=`RESET_PC`.
- Reset during FETCH or HOLD discards any outstanding request and the held instruction.
- Zero-wait memory (`imem_valid` in the same cycle as `imem_req`): the instruction is registered at the next edge, giving `instr_valid`=1 one cycle after the request.
- With `instr_ready` tied high, throughput is 1 instruction per 2 cycles.
- A memory wait of N cycles adds N cycles.
- PC update and `instret` increment take effect at the consuming edge, so the next request address is visible in the following cycle.
- All outputs are registered or decoded from registered state only. No combinational path exists from `imem_*` or `instr_ready` to outputs, except that `imem_req` depends on state.

## Test plan
- Reset release, zero-wait memory returning 32'h00500093, `instr_ready`=1:
  - cycle 0: `imem_addr`=0.
  - cycle 1: `instr_valid`=1, `opcode`=0010011, `rd`=1, `funct3`=0.
  - cycle 2: `imem_addr`=4, `instret`=1.
- Memory delays `imem_valid` by 3 cycles:
  - `imem_req`/`imem_addr` stay stable for 4 cycles.
  - `instr_valid` rises the cycle after `imem_valid`.
  - Hold `instr_ready`=0 for 5 cycles: `instr`, `pc` and `instret` are unchanged.
- Consume with `branch`=1, `zero`=1, `target_pc`=32'h40 at `pc`=8 → next `imem_addr`=32'h40.
- Same instruction with `zero`=0 → next `imem_addr`=12.
- `jump`=1, `target_pc`=32'h102:
  - `fault`=1, state FAULT, `imem_req`=0, `pc`=old value, `instret` unchanged.
  - Pulsing `rst_n` low clears all outputs to reset values.
- `pc`=32'hFFFF_FFFC, not taken, consumed → `imem_addr`=0 and `fault`=0.
- `instret` preloaded near wrap by consuming 32'hFFFF_FFFF instructions (or via a forced value), then one more consume → `instret`=0.
